wb_arbiter: RTL and testbench



---
 rtl/wb_arbiter_pkg.sv | 12 +
 rtl/wb_fifo.sv | 59 +++++
 rtl/wb_arbiter.sv | 112 +++++++++++
 tb/tb_wb_arbiter.sv | 335 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/wb_arbiter_pkg.sv
// Shared types for the writeback arbiter: the buffered MDU result
// record and the architectural zero register.
package wb_arbiter_pkg;

    typedef struct packed {
        logic [4:0]  rd;
        logic [31:0] data;
    } wb_entry_t;

    localparam logic [4:0] REG_ZERO = 5'd0;

endpackage

// File: rtl/wb_fifo.sv
// Synchronous FIFO of writeback entries; DEPTH must be a power of two
// so the pointers wrap naturally.
module wb_fifo
    import wb_arbiter_pkg::*;
#(
    parameter int DEPTH = 2
) (
    input  logic      clk,
    input  logic      rst,
    input  logic      i_push,
    input  wb_entry_t i_data,
    input  logic      i_pop,
    output wb_entry_t o_head,
    output logic      o_full,
    output logic      o_empty
);

    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    wb_entry_t      r_mem [DEPTH];
    logic [AW-1:0]  r_head;
    logic [AW-1:0]  r_tail;
    logic [AW:0]    r_count;
    logic           w_push;
    logic           w_pop;

    assign o_full  = (r_count == (AW+1)'(DEPTH));
    assign o_empty = (r_count == '0);
    assign w_push  = i_push && !o_full;
    assign w_pop   = i_pop && !o_empty;
    assign o_head  = r_mem[r_head];

    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[r_tail] <= i_data;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_head  <= '0;
            r_tail  <= '0;
            r_count <= '0;
        end else begin
            if (w_push) begin
                r_tail <= r_tail + 1'b1;
            end
            if (w_pop) begin
                r_head <= r_head + 1'b1;
            end
            unique case ({w_push, w_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

endmodule

// File: rtl/wb_arbiter.sv
// Regfile write-port arbiter: merges in-order pipeline results with
// buffered MDU results and tracks outstanding MDU destinations.
module wb_arbiter
    import wb_arbiter_pkg::*;
#(
    parameter int DEPTH = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        pipe_valid,
    input  logic [4:0]  pipe_rd,
    input  logic [31:0] pipe_data,
    output logic        pipe_stall,
    input  logic        issue_valid,
    input  logic [4:0]  issue_rd,
    input  logic        mdu_valid,
    output logic        mdu_ready,
    input  logic [4:0]  mdu_rd,
    input  logic [31:0] mdu_data,
    output logic        rf_load,
    output logic [4:0]  rf_dest,
    output logic [31:0] rf_in,
    output logic        rf_use_rd,
    output logic [31:0] pend_mask
);

    wb_entry_t   w_head;
    wb_entry_t   w_push_data;
    logic        w_full;
    logic        w_empty;
    logic        w_push;
    logic        w_pipe_req;
    logic        w_fifo_win;
    logic        w_pipe_win;
    logic [31:0] w_pend_nxt;
    logic [31:0] r_pend;

    assign mdu_ready   = !w_full && !rst;
    assign w_push      = mdu_valid && mdu_ready;
    assign w_push_data = '{rd: mdu_rd, data: mdu_data};
    assign w_pipe_req  = pipe_valid && (pipe_rd != REG_ZERO);

    wb_fifo #(
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk     (clk),
        .rst     (rst),
        .i_push  (w_push),
        .i_data  (w_push_data),
        .i_pop   (w_fifo_win),
        .o_head  (w_head),
        .o_full  (w_full),
        .o_empty (w_empty)
    );

    // A full FIFO takes priority so the MDU can never be starved.
    always_comb begin
        w_fifo_win = 1'b0;
        w_pipe_win = 1'b0;
        pipe_stall = 1'b0;
        if (!rst) begin
            if (w_full && !w_empty) begin
                w_fifo_win = 1'b1;
                pipe_stall = pipe_valid;
            end else if (w_pipe_req) begin
                w_pipe_win = 1'b1;
            end else if (!w_empty) begin
                w_fifo_win = 1'b1;
            end
        end
    end

    always_comb begin
        rf_load = 1'b0;
        rf_dest = '0;
        rf_in   = '0;
        if (w_fifo_win && (w_head.rd != REG_ZERO)) begin
            rf_load = 1'b1;
            rf_dest = w_head.rd;
            rf_in   = w_head.data;
        end else if (w_pipe_win) begin
            rf_load = 1'b1;
            rf_dest = pipe_rd;
            rf_in   = pipe_data;
        end
    end

    assign rf_use_rd = rf_load;

    // A new issue to the same register overrides the retiring result.
    always_comb begin
        w_pend_nxt = r_pend;
        if (w_fifo_win && rf_load) begin
            w_pend_nxt[rf_dest] = 1'b0;
        end
        if (issue_valid && (issue_rd != REG_ZERO)) begin
            w_pend_nxt[issue_rd] = 1'b1;
        end
        w_pend_nxt[0] = 1'b0;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_pend <= '0;
        end else begin
            r_pend <= w_pend_nxt;
        end
    end

    assign pend_mask = r_pend;

endmodule

// File: tb/tb_wb_arbiter.sv
// Self-checking bench for wb_arbiter: pipe-only vector table plus
// scripted MDU/pipe sequences, with a write-order scoreboard.
module tb_wb_arbiter;
    import wb_arbiter_pkg::*;

    logic        clk;
    logic        rst;
    logic        pipe_valid;
    logic [4:0]  pipe_rd;
    logic [31:0] pipe_data;
    logic        pipe_stall;
    logic        issue_valid;
    logic [4:0]  issue_rd;
    logic        mdu_valid;
    logic        mdu_ready;
    logic [4:0]  mdu_rd;
    logic [31:0] mdu_data;
    logic        rf_load;
    logic [4:0]  rf_dest;
    logic [31:0] rf_in;
    logic        rf_use_rd;
    logic [31:0] pend_mask;

    int n_cmp = 0;
    int n_bad = 0;
    wb_entry_t exp_q[$];

    typedef struct {
        logic        pv;
        logic [4:0]  rd;
        logic [31:0] data;
        logic        load;
        logic [4:0]  dest;
        logic [31:0] din;
        logic        stall;
    } vec_t;

    vec_t tbl[5];

    wb_arbiter #(
        .DEPTH (2)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .pipe_valid  (pipe_valid),
        .pipe_rd     (pipe_rd),
        .pipe_data   (pipe_data),
        .pipe_stall  (pipe_stall),
        .issue_valid (issue_valid),
        .issue_rd    (issue_rd),
        .mdu_valid   (mdu_valid),
        .mdu_ready   (mdu_ready),
        .mdu_rd      (mdu_rd),
        .mdu_data    (mdu_data),
        .rf_load     (rf_load),
        .rf_dest     (rf_dest),
        .rf_in       (rf_in),
        .rf_use_rd   (rf_use_rd),
        .pend_mask   (pend_mask)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h want %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        pipe_valid  = 1'b0;
        pipe_rd     = '0;
        pipe_data   = '0;
        issue_valid = 1'b0;
        issue_rd    = '0;
        mdu_valid   = 1'b0;
        mdu_rd      = '0;
        mdu_data    = '0;
    endtask

    task automatic issue(input logic [4:0] rd);
        issue_valid = 1'b1;
        issue_rd    = rd;
        tick();
        issue_valid = 1'b0;
        issue_rd    = '0;
    endtask

    task automatic push_exp(input logic [4:0] rd, input logic [31:0] d);
        exp_q.push_back('{rd: rd, data: d});
    endtask

    // Every regfile write must match the oldest expected write.
    always @(negedge clk) begin
        if (!rst && rf_load) begin
            if (exp_q.size() == 0) begin
                n_cmp++;
                n_bad++;
                $display("FAIL unexpected_write: got x%0d=%h want none",
                         rf_dest, rf_in);
            end else begin
                wb_entry_t e;
                e = exp_q.pop_front();
                chk("wr_dest", 32'(rf_dest), 32'(e.rd));
                chk("wr_data", rf_in, e.data);
                chk("wr_use_rd", 32'(rf_use_rd), 32'd1);
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1);
    end

    initial begin
        tbl[0] = '{1'b1, 5'd1,  32'h1111_0001, 1'b1, 5'd1,  32'h1111_0001, 1'b0};
        tbl[1] = '{1'b1, 5'd31, 32'hFFFF_001F, 1'b1, 5'd31, 32'hFFFF_001F, 1'b0};
        tbl[2] = '{1'b1, 5'd0,  32'hBAD0_0000, 1'b0, 5'd0,  32'h0,         1'b0};
        tbl[3] = '{1'b0, 5'd4,  32'hBAD0_0004, 1'b0, 5'd0,  32'h0,         1'b0};
        tbl[4] = '{1'b1, 5'd17, 32'h0A0B_0C0D, 1'b1, 5'd17, 32'h0A0B_0C0D, 1'b0};

        idle();
        rst        = 1'b1;
        pipe_valid = 1'b1;
        pipe_rd    = 5'd3;
        mdu_valid  = 1'b1;
        mdu_rd     = 5'd4;
        tick();
        tick();
        #2;
        chk("rst_ready", 32'(mdu_ready), 32'd0);
        chk("rst_load", 32'(rf_load), 32'd0);
        chk("rst_stall", 32'(pipe_stall), 32'd0);
        tick();
        rst = 1'b0;
        idle();
        for (int i = 0; i < 10; i++) begin
            #2;
            chk("idle_pend", pend_mask, 32'h0);
            chk("idle_ready", 32'(mdu_ready), 32'd1);
            chk("idle_load", 32'(rf_load), 32'd0);
            tick();
        end

        for (int i = 0; i < 5; i++) begin
            pipe_valid = tbl[i].pv;
            pipe_rd    = tbl[i].rd;
            pipe_data  = tbl[i].data;
            #2;
            chk("tbl_load", 32'(rf_load), 32'(tbl[i].load));
            chk("tbl_dest", 32'(rf_dest), 32'(tbl[i].dest));
            chk("tbl_in", rf_in, tbl[i].din);
            chk("tbl_stall", 32'(pipe_stall), 32'(tbl[i].stall));
            if (tbl[i].load) begin
                push_exp(tbl[i].dest, tbl[i].din);
            end
            tick();
        end
        idle();

        issue(5'd5);
        mdu_valid = 1'b1;
        mdu_rd    = 5'd5;
        mdu_data  = 32'hDEAD_BEEF;
        #2;
        chk("s2_pend_set", pend_mask, 32'h0000_0020);
        chk("s2_no_bypass", 32'(rf_load), 32'd0);
        push_exp(5'd5, 32'hDEAD_BEEF);
        tick();
        idle();
        #2;
        chk("s2_load", 32'(rf_load), 32'd1);
        chk("s2_dest", 32'(rf_dest), 32'd5);
        chk("s2_in", rf_in, 32'hDEAD_BEEF);
        chk("s2_use_rd", 32'(rf_use_rd), 32'd1);
        chk("s2_pend_hold", pend_mask, 32'h0000_0020);
        tick();
        #2;
        chk("s2_pend_clr", pend_mask, 32'h0);
        tick();

        issue(5'd7);
        issue(5'd8);
        pipe_valid = 1'b1;
        pipe_rd    = 5'd3;
        pipe_data  = 32'h3000_0000;
        mdu_valid  = 1'b1;
        mdu_rd     = 5'd7;
        mdu_data   = 32'h7777_7777;
        #2;
        chk("s3a_dest", 32'(rf_dest), 32'd3);
        push_exp(5'd3, 32'h3000_0000);
        tick();
        pipe_data = 32'h3000_0001;
        mdu_rd    = 5'd8;
        mdu_data  = 32'h8888_8888;
        #2;
        chk("s3b_ready", 32'(mdu_ready), 32'd1);
        chk("s3b_dest", 32'(rf_dest), 32'd3);
        push_exp(5'd3, 32'h3000_0001);
        tick();
        mdu_valid = 1'b0;
        pipe_data = 32'h3000_0002;
        #2;
        chk("s3c_ready", 32'(mdu_ready), 32'd0);
        chk("s3c_stall", 32'(pipe_stall), 32'd1);
        chk("s3c_dest", 32'(rf_dest), 32'd7);
        chk("s3c_in", rf_in, 32'h7777_7777);
        push_exp(5'd7, 32'h7777_7777);
        tick();
        #2;
        chk("s3d_stall", 32'(pipe_stall), 32'd0);
        chk("s3d_ready", 32'(mdu_ready), 32'd1);
        chk("s3d_in", rf_in, 32'h3000_0002);
        chk("s3d_pend", pend_mask, 32'h0000_0100);
        push_exp(5'd3, 32'h3000_0002);
        tick();
        idle();
        #2;
        chk("s3e_dest", 32'(rf_dest), 32'd8);
        push_exp(5'd8, 32'h8888_8888);
        tick();
        #2;
        chk("s3_pend_clr", pend_mask, 32'h0);
        chk("s3_idle_load", 32'(rf_load), 32'd0);

        issue(5'd12);
        pipe_valid = 1'b1;
        pipe_rd    = 5'd0;
        mdu_valid  = 1'b1;
        mdu_rd     = 5'd0;
        mdu_data   = 32'h5555_0000;
        #2;
        chk("s4a_load", 32'(rf_load), 32'd0);
        chk("s4a_stall", 32'(pipe_stall), 32'd0);
        tick();
        mdu_data = 32'h5555_0001;
        #2;
        chk("s4b_load", 32'(rf_load), 32'd0);
        tick();
        mdu_valid = 1'b0;
        #2;
        chk("s4c_ready", 32'(mdu_ready), 32'd1);
        chk("s4c_load", 32'(rf_load), 32'd0);
        chk("s4c_pend", pend_mask, 32'h0000_1000);
        tick();
        pipe_valid = 1'b0;
        mdu_valid  = 1'b1;
        mdu_rd     = 5'd12;
        mdu_data   = 32'h1200_00CC;
        push_exp(5'd12, 32'h1200_00CC);
        tick();
        idle();
        #2;
        chk("s4e_load", 32'(rf_load), 32'd1);
        chk("s4e_dest", 32'(rf_dest), 32'd12);
        tick();
        #2;
        chk("s4_pend_clr", pend_mask, 32'h0);

        issue(5'd9);
        mdu_valid = 1'b1;
        mdu_rd    = 5'd9;
        mdu_data  = 32'h9999_0000;
        push_exp(5'd9, 32'h9999_0000);
        tick();
        mdu_valid   = 1'b0;
        issue_valid = 1'b1;
        issue_rd    = 5'd9;
        #2;
        chk("s5_load", 32'(rf_load), 32'd1);
        chk("s5_dest", 32'(rf_dest), 32'd9);
        tick();
        idle();
        #2;
        chk("s5_pend_kept", pend_mask, 32'h0000_0200);
        mdu_valid = 1'b1;
        mdu_rd    = 5'd9;
        mdu_data  = 32'h9999_0001;
        push_exp(5'd9, 32'h9999_0001);
        tick();
        idle();
        tick();
        #2;
        chk("s5_pend_clr", pend_mask, 32'h0);

        issue(5'd5);
        issue(5'd8);
        pipe_valid = 1'b1;
        pipe_rd    = 5'd3;
        pipe_data  = 32'h3300_0000;
        mdu_valid  = 1'b1;
        mdu_rd     = 5'd5;
        mdu_data   = 32'h5500_0000;
        push_exp(5'd3, 32'h3300_0000);
        tick();
        pipe_data = 32'h3300_0001;
        mdu_rd    = 5'd8;
        mdu_data  = 32'h8800_0000;
        push_exp(5'd3, 32'h3300_0001);
        tick();
        idle();
        rst = 1'b1;
        #2;
        chk("s6_pend_pre", pend_mask, 32'h0000_0120);
        chk("s6_rst_ready", 32'(mdu_ready), 32'd0);
        chk("s6_rst_load", 32'(rf_load), 32'd0);
        tick();
        rst = 1'b0;
        #2;
        chk("s6_pend_rst", pend_mask, 32'h0);
        chk("s6_ready", 32'(mdu_ready), 32'd1);
        chk("s6_load", 32'(rf_load), 32'd0);
        tick();
        #2;
        chk("s6_load2", 32'(rf_load), 32'd0);
        tick();

        chk("queue_empty", 32'(exp_q.size()), 32'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
